// File: rtl/serializer_sched_if.sv
// rtl/serializer_sched_if.sv - requester and serializer signal bundle for serializer_sched
//
// Purpose: groups the requester handshake, the serializer-side lane signals and
// the status outputs of serializer_sched into one bundle.
// Ports (signals):
//   req_valid_i  [NUM_REQ]     requester i has a frame pending
//   req_data_i   [NUM_REQ*27]  frame of requester i at [27*i +: 27]
//   req_ready_o  [NUM_REQ]     one-hot accept strobe
//   sym_tick_i                 serializer symbol-boundary pulse
//   start_o                    serializer start pulse
//   frame_o      [27]          frame presented to the serializer
//   grant_id_o   [3]           owner of the current frame
//   busy_o                     frame in flight
//   err_o                      sticky watchdog error
// master: drives requests and ticks (requesters + serializer); slave: the scheduler.
interface serializer_sched_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ*27-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic                  sym_tick_i;
    logic                  start_o;
    logic [26:0]           frame_o;
    logic [2:0]            grant_id_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        output req_valid_i, req_data_i, sym_tick_i,
        input  req_ready_o, start_o, frame_o, grant_id_o, busy_o, err_o
    );

    modport slave (
        input  req_valid_i, req_data_i, sym_tick_i,
        output req_ready_o, start_o, frame_o, grant_id_o, busy_o, err_o
    );
endinterface

// File: rtl/serializer_sched.sv
// rtl/serializer_sched.sv - round-robin frame scheduler for the 27-bit symbol serializer
//
// Purpose: shares one serial lane between NUM_REQ requesters. A frame is
// accepted per grant, held on frame_o, start_o pulses once, then SYMS_PER_FRAME
// symbol ticks are counted before the lane is released. A watchdog aborts a
// frame whose ticks stall for TICK_TIMEOUT cycles and sets a sticky error.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active-high
//   bus    serializer_sched_if.slave (requests, lane control, status)
module serializer_sched #(
    parameter int NUM_REQ        = 4,
    parameter int SYMS_PER_FRAME = 4,
    parameter int TICK_TIMEOUT   = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    serializer_sched_if.slave  bus
);
    // Widths sized to hold the terminal count without wrapping.
    localparam int TCW = $clog2(SYMS_PER_FRAME + 1);
    localparam int WDW = $clog2(TICK_TIMEOUT + 1);
    localparam logic [TCW-1:0] TICK_LAST  = TCW'(SYMS_PER_FRAME - 1);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(TICK_TIMEOUT - 1);
    localparam logic [26:0]    COMMA_FILL = {3{9'h13C}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [26:0]        frame_q, frame_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         last_q, last_d;
    logic [TCW-1:0]     tick_q, tick_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] ready;

    logic               found;
    logic [2:0]         pick;
    logic [3:0]         idx;
    logic [26:0]        pick_data;

    // Round-robin pick: first valid requester searching upward from last+1.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        idx       = '0;
        pick_data = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_q} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && idx == 4'(j) && bus.req_valid_i[j]) begin
                    found = 1'b1;
                    pick  = 3'(j);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == 3'(j)) begin
                pick_data = bus.req_data_i[27*j +: 27];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            frame_q <= COMMA_FILL;
            grant_q <= '0;
            last_q  <= 3'(NUM_REQ - 1);
            tick_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tick_q  <= tick_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        grant_d = grant_q;
        last_d  = last_q;
        tick_d  = tick_q;
        wd_d    = wd_q;
        err_d   = err_q;
        ready   = '0;
        unique case (state_q)
            S_IDLE: begin
                // Ready is masked during reset so no frame is handed over on
                // an edge that discards it.
                if (found && !rst_i) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        ready[j] = (pick == 3'(j));
                    end
                    frame_d = pick_data;
                    grant_d = pick;
                    last_d  = pick;
                    state_d = S_START;
                end
            end
            S_START: begin
                tick_d  = '0;
                wd_d    = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (bus.sym_tick_i) begin
                    wd_d = '0;
                    if (tick_q == TICK_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    frame_d = COMMA_FILL;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready_o = ready;
    assign bus.start_o     = (state_q == S_START);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.frame_o     = frame_q;
    assign bus.grant_id_o  = grant_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_serializer_sched.sv
// tb/tb_serializer_sched.sv - randomized self-checking bench for serializer_sched
module tb_serializer_sched;
    localparam int NR = 4;
    localparam logic [26:0] COMMA = {3{9'h13C}};

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    serializer_sched_if #(.NUM_REQ(NR)) sif ();

    serializer_sched #(
        .NUM_REQ(NR),
        .SYMS_PER_FRAME(4),
        .TICK_TIMEOUT(64)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(sif.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ref_last;
    logic [26:0] dat [NR];

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic pack();
        for (int j = 0; j < NR; j++) sif.req_data_i[27*j +: 27] = dat[j];
    endtask

    task automatic new_data();
        for (int j = 0; j < NR; j++) dat[j] = 27'($urandom);
        pack();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        sif.req_valid_i = '0;
        sif.sym_tick_i = 1'b0;
        cyc();
        cyc();
        rst_i = 1'b0;
        #1;
        ref_last = NR - 1;
    endtask

    // Reference arbitration: first valid index after the last grant, wrapping.
    function automatic int rr_pick(int last, logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic wait_ready(output logic [NR-1:0] seen);
        for (int i = 0; i < 20; i++) begin
            if (sif.req_ready_o != '0) break;
            cyc();
            #1;
        end
        seen = sif.req_ready_o;
    endtask

    // Issues single-cycle ticks spaced by gap and reports how many ticks it
    // took for busy_o to fall (-1 if it never fell within 8 ticks).
    task automatic finish_frame(input int gap, output int n);
        n = -1;
        for (int i = 1; i <= 8; i++) begin
            repeat (gap - 1) begin
                cyc();
                sif.sym_tick_i = 1'b0;
                #1;
            end
            cyc();
            sif.sym_tick_i = 1'b1;
            #1;
            cyc();
            sif.sym_tick_i = 1'b0;
            #1;
            if (!sif.busy_o) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        sif.req_valid_i = '1;
        sif.sym_tick_i = 1'b0;
        new_data();
        cyc();
        cyc();
        #1;
        n_cmp++; if (sif.req_ready_o !== '0) begin n_bad++; $display("FAIL reset_ready: got %b exp 0", sif.req_ready_o); end
        n_cmp++; if (sif.start_o !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b exp 0", sif.start_o); end
        n_cmp++; if (sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", sif.busy_o); end
        n_cmp++; if (sif.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", sif.err_o); end
        n_cmp++; if (sif.frame_o !== COMMA) begin n_bad++; $display("FAIL reset_frame: got %h exp %h", sif.frame_o, COMMA); end
        n_cmp++; if (sif.grant_id_o !== 3'd0) begin n_bad++; $display("FAIL reset_grant: got %0d exp 0", sif.grant_id_o); end
        sif.req_valid_i = '0;
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        logic [NR-1:0] seen;
        int n;
        do_reset();
        new_data();
        dat[2] = 27'h1ABCDEF;
        pack();
        cyc();
        sif.req_valid_i = 4'b0100;
        #1;
        wait_ready(seen);
        n_cmp++; if (seen !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b exp 0100", seen); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        n_cmp++; if (sif.start_o !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b exp 1", sif.start_o); end
        n_cmp++; if (sif.frame_o !== 27'h1ABCDEF) begin n_bad++; $display("FAIL single_frame: got %h exp 1abcdef", sif.frame_o); end
        n_cmp++; if (sif.grant_id_o !== 3'd2) begin n_bad++; $display("FAIL single_grant: got %0d exp 2", sif.grant_id_o); end
        n_cmp++; if (sif.req_ready_o !== '0) begin n_bad++; $display("FAIL single_ready_start: got %b exp 0", sif.req_ready_o); end
        finish_frame(3, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL single_ticks: got %0d exp 4", n); end
        n_cmp++; if (sif.start_o !== 1'b0) begin n_bad++; $display("FAIL single_start_idle: got %b exp 0", sif.start_o); end
        n_cmp++; if (sif.frame_o !== 27'h1ABCDEF) begin n_bad++; $display("FAIL single_frame_hold: got %h exp 1abcdef", sif.frame_o); end
    endtask

    task automatic test_rotation();
        logic [NR-1:0] seen, e;
        logic [26:0] exp_f;
        int n;
        do_reset();
        new_data();
        cyc();
        sif.req_valid_i = '1;
        #1;
        for (int f = 0; f < 5; f++) begin
            wait_ready(seen);
            e = '0;
            e[f % NR] = 1'b1;
            exp_f = dat[f % NR];
            n_cmp++; if (seen !== e) begin n_bad++; $display("FAIL rot_ready[%0d]: got %b exp %b", f, seen, e); end
            cyc();
            dat[f % NR] = 27'($urandom);
            pack();
            #1;
            n_cmp++; if (sif.start_o !== 1'b1) begin n_bad++; $display("FAIL rot_start[%0d]: got %b exp 1", f, sif.start_o); end
            n_cmp++; if (sif.frame_o !== exp_f) begin n_bad++; $display("FAIL rot_frame[%0d]: got %h exp %h", f, sif.frame_o, exp_f); end
            n_cmp++; if (sif.grant_id_o !== 3'(f % NR)) begin n_bad++; $display("FAIL rot_grant[%0d]: got %0d exp %0d", f, sif.grant_id_o, f % NR); end
            finish_frame(8, n);
            n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL rot_ticks[%0d]: got %0d exp 4", f, n); end
            n_cmp++; if (sif.frame_o !== exp_f) begin n_bad++; $display("FAIL rot_frame_hold[%0d]: got %h exp %h", f, sif.frame_o, exp_f); end
        end
        sif.req_valid_i = '0;
    endtask

    task automatic test_watchdog();
        logic [NR-1:0] seen;
        logic err64;
        int n;
        do_reset();
        new_data();
        cyc();
        sif.req_valid_i = 4'b0001;
        #1;
        wait_ready(seen);
        n_cmp++; if (seen !== 4'b0001) begin n_bad++; $display("FAIL wd_ready: got %b exp 0001", seen); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        n = -1;
        err64 = 1'bx;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            #1;
            if (i == 64) err64 = sif.err_o;
            if (!sif.busy_o) begin
                n = i;
                break;
            end
        end
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL wd_abort_cycle: got %0d exp 65", n); end
        n_cmp++; if (err64 !== 1'b0) begin n_bad++; $display("FAIL wd_err_early: got %b exp 0", err64); end
        n_cmp++; if (sif.err_o !== 1'b1) begin n_bad++; $display("FAIL wd_err: got %b exp 1", sif.err_o); end
        n_cmp++; if (sif.frame_o !== COMMA) begin n_bad++; $display("FAIL wd_frame: got %h exp %h", sif.frame_o, COMMA); end
        repeat (3) cyc();
        sif.req_valid_i = 4'b0011;
        #1;
        wait_ready(seen);
        n_cmp++; if (seen !== 4'b0010) begin n_bad++; $display("FAIL wd_next_ready: got %b exp 0010", seen); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        n_cmp++; if (sif.frame_o !== dat[1]) begin n_bad++; $display("FAIL wd_next_frame: got %h exp %h", sif.frame_o, dat[1]); end
        finish_frame(2, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL wd_next_ticks: got %0d exp 4", n); end
        n_cmp++; if (sif.err_o !== 1'b1) begin n_bad++; $display("FAIL wd_err_sticky: got %b exp 1", sif.err_o); end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] seen;
        do_reset();
        new_data();
        cyc();
        sif.req_valid_i = 4'b0010;
        #1;
        wait_ready(seen);
        n_cmp++; if (seen !== 4'b0010) begin n_bad++; $display("FAIL rmid_ready: got %b exp 0010", seen); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        cyc();
        #1;
        repeat (2) begin
            cyc();
            sif.sym_tick_i = 1'b1;
            #1;
            cyc();
            sif.sym_tick_i = 1'b0;
            #1;
        end
        n_cmp++; if (sif.busy_o !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b exp 1", sif.busy_o); end
        cyc();
        rst_i = 1'b1;
        sif.req_valid_i = '1;
        #1;
        cyc();
        rst_i = 1'b0;
        #1;
        n_cmp++; if (sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b exp 0", sif.busy_o); end
        n_cmp++; if (sif.frame_o !== COMMA) begin n_bad++; $display("FAIL rmid_frame: got %h exp %h", sif.frame_o, COMMA); end
        n_cmp++; if (sif.grant_id_o !== 3'd0) begin n_bad++; $display("FAIL rmid_grant: got %0d exp 0", sif.grant_id_o); end
        n_cmp++; if (sif.req_ready_o !== 4'b0001) begin n_bad++; $display("FAIL rmid_first_ready: got %b exp 0001", sif.req_ready_o); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        n_cmp++; if (sif.start_o !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got %b exp 1", sif.start_o); end
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        #1;
        n_cmp++; if (sif.start_o !== 1'b0) begin n_bad++; $display("FAIL rmid_start_rst: got %b exp 0", sif.start_o); end
        n_cmp++; if (sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_rst: got %b exp 0", sif.busy_o); end
    endtask

    task automatic test_idle_ticks();
        logic [NR-1:0] seen;
        int n;
        do_reset();
        new_data();
        cyc();
        sif.sym_tick_i = 1'b1;
        #1;
        repeat (2) cyc();
        #1;
        n_cmp++; if (sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL itick_busy: got %b exp 0", sif.busy_o); end
        cyc();
        sif.req_valid_i = 4'b0100;
        #1;
        wait_ready(seen);
        n_cmp++; if (seen !== 4'b0100) begin n_bad++; $display("FAIL itick_ready: got %b exp 0100", seen); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        n_cmp++; if (sif.start_o !== 1'b1) begin n_bad++; $display("FAIL itick_start: got %b exp 1", sif.start_o); end
        finish_frame(2, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL itick_ticks: got %0d exp 4", n); end
    endtask

    task automatic test_drop_valid();
        logic [NR-1:0] seen;
        int n, stray;
        do_reset();
        new_data();
        cyc();
        sif.req_valid_i = 4'b0001;
        #1;
        wait_ready(seen);
        n_cmp++; if (seen !== 4'b0001) begin n_bad++; $display("FAIL drop_ready0: got %b exp 0001", seen); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        cyc();
        sif.req_valid_i = 4'b0010;
        #1;
        n_cmp++; if (sif.req_ready_o !== '0) begin n_bad++; $display("FAIL drop_ready_busy: got %b exp 0", sif.req_ready_o); end
        cyc();
        sif.req_valid_i = '0;
        #1;
        finish_frame(2, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL drop_ticks: got %0d exp 4", n); end
        stray = 0;
        repeat (4) begin
            cyc();
            #1;
            if (sif.busy_o || sif.req_ready_o != '0) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL drop_no_grant: got %0d stray cycles exp 0", stray); end
    endtask

    task automatic test_random();
        logic [NR-1:0] seen, v, e;
        logic [26:0] exp_f;
        int g, n;
        do_reset();
        for (int f = 0; f < 12; f++) begin
            new_data();
            v = NR'($urandom_range(1, (1 << NR) - 1));
            cyc();
            sif.req_valid_i = v;
            #1;
            wait_ready(seen);
            g = rr_pick(ref_last, v);
            e = '0;
            e[g] = 1'b1;
            exp_f = dat[g];
            n_cmp++; if (seen !== e) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b exp %b (valid %b)", f, seen, e, v); end
            cyc();
            sif.req_valid_i = '0;
            #1;
            n_cmp++; if (sif.frame_o !== exp_f) begin n_bad++; $display("FAIL rnd_frame[%0d]: got %h exp %h", f, sif.frame_o, exp_f); end
            n_cmp++; if (sif.grant_id_o !== 3'(g)) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %0d exp %0d", f, sif.grant_id_o, g); end
            finish_frame(int'($urandom_range(1, 5)), n);
            n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL rnd_ticks[%0d]: got %0d exp 4", f, n); end
            ref_last = g;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        sif.req_valid_i = '0;
        sif.req_data_i = '0;
        sif.sym_tick_i = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_watchdog();
        test_reset_mid();
        test_idle_ticks();
        test_drop_valid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
